// File: rtl/ctrl_pkg.sv
//============================================================================
// Module   : ctrl_pkg
// Brief    : Shared state encoding and default widths for the control-unit
//            timing-step generator.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package ctrl_pkg;

   // Controller state encoding
   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] RUN    = 2'd1;
   localparam logic [STATE_W-1:0] HALTED = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = IDLE,
      ST_RUN    = RUN,
      ST_HALTED = HALTED
   } state_e;

   // Defaults matching the 3-to-8 step decoder and a six-step instruction
   localparam int DEF_STEP_W    = 3;
   localparam int DEF_LAST_STEP = 5;
   localparam int DEF_CNT_W     = 8;

endpackage

`default_nettype wire

// File: rtl/step_edge_det.sv
//============================================================================
// Module   : step_edge_det
// Brief    : 1-bit rising-edge detector. The input is assumed to be already
//            synchronised to clk; the previous value is registered and a
//            rise is flagged combinationally from it.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module step_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o
);

   logic prev_q;

   // Remember the last sampled level so a 0->1 transition can be seen
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= d_i;
      end
   end

   assign rise_o = d_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/ctrl_step_counter.sv
//============================================================================
// Module   : ctrl_step_counter
// Brief    : Timing-step generator for the control unit. Sequences the step
//            code 0..LAST_STEP per instruction with early end (step_clr),
//            stall, halt-at-boundary and resume, and counts retired
//            instructions. Optional single-step mode is enabled by defining
//            the macro CTRL_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module ctrl_step_counter
   import ctrl_pkg::*;
#(
   parameter int STEP_W    = DEF_STEP_W,
   parameter int LAST_STEP = DEF_LAST_STEP,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic              single_step,
   input  logic              step_btn,
`endif
   input  logic              start,
   input  logic              stall,
   input  logic              step_clr,
   input  logic              halt_req,
   output logic [STEP_W-1:0] step,
   output logic              running,
   output logic              halted,
   output logic              instr_done,
   output logic [CNT_W-1:0]  instr_cnt
);

   localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(LAST_STEP);
   localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
   localparam logic [STEP_W-1:0] C_STEP_ONE  = STEP_W'(1);

   state_e              state_q;
   logic [STEP_W-1:0]   step_q;
   logic [STEP_W-1:0]   step_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                running_q;
   logic                halted_q;
   logic                done_q;

   logic                w_boundary;
   logic                w_advance;

`ifdef CTRL_SINGLE_STEP_EN
   logic                w_btn_rise;

   step_edge_det u_step_edge_det (
      .clk    (clk),
      .rst    (rst),
      .d_i    (step_btn),
      .rise_o (w_btn_rise)
   );

   // In single-step mode a cycle without a button edge behaves as a stall
   assign w_advance = ~stall & (~single_step | w_btn_rise);
`else
   assign w_advance = ~stall;
`endif

   // Next step and count values for a non-stalled RUN cycle
   always_comb begin
      w_boundary = (step_q == C_LAST_STEP) || step_clr;
      cnt_d      = cnt_q + C_CNT_ONE;
      if (w_boundary) begin
         step_d = '0;
      end else begin
         step_d = step_q + C_STEP_ONE;
      end
   end

   // Controller FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               step_q <= '0;
               if (start) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
                  halted_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_advance) begin
                  step_q <= step_d;
                  if (w_boundary) begin
                     done_q <= 1'b1;
                     cnt_q  <= cnt_d;
                     // halt_req is only honoured at an instruction boundary
                     if (halt_req) begin
                        state_q   <= ST_HALTED;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                     end
                  end
               end
            end
            ST_HALTED: begin
               step_q <= '0;
               if (start) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
                  halted_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               step_q    <= '0;
               running_q <= 1'b0;
               halted_q  <= 1'b0;
            end
         endcase
      end
   end

   assign step       = step_q;
   assign running    = running_q;
   assign halted     = halted_q;
   assign instr_done = done_q;
   assign instr_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_step_counter.sv
//============================================================================
// Module   : tb_ctrl_step_counter
// Brief    : Self-checking bench for ctrl_step_counter. A table of per-cycle
//            input/expected-output records is driven; expectations are
//            queued when stimulus is applied and compared after the edge.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ctrl_step_counter;

   typedef struct {
      string      name;
      logic       rst;
      logic       start;
      logic       stall;
      logic       clr;
      logic       hreq;
      logic [2:0] e_step;
      logic       e_run;
      logic       e_halt;
      logic       e_done;
      logic [7:0] e_cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       step_clr = 1'b0;
   logic       halt_req = 1'b0;
   logic [2:0] step;
   logic       running;
   logic       halted;
   logic       instr_done;
   logic [7:0] instr_cnt;
`ifdef CTRL_SINGLE_STEP_EN
   logic       single_step = 1'b0;
   logic       step_btn = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   ctrl_step_counter #(
      .STEP_W    (3),
      .LAST_STEP (5),
      .CNT_W     (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef CTRL_SINGLE_STEP_EN
      .single_step(single_step),
      .step_btn   (step_btn),
`endif
      .start      (start),
      .stall      (stall),
      .step_clr   (step_clr),
      .halt_req   (halt_req),
      .step       (step),
      .running    (running),
      .halted     (halted),
      .instr_done (instr_done),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input bit r, input bit s, input bit st,
                               input bit c, input bit h, input int es, input bit er,
                               input bit eh, input bit ed, input int ec);
      vec_t t;
      t.name = n; t.rst = r; t.start = s; t.stall = st; t.clr = c; t.hreq = h;
      t.e_step = 3'(es); t.e_run = er; t.e_halt = eh; t.e_done = ed; t.e_cnt = 8'(ec);
      return t;
   endfunction

   // Pop the oldest expectation and compare it to the current outputs
   task automatic check_out();
      vec_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expectation queued");
      end else begin
         e = exp_q.pop_front();
         if ({step, running, halted, instr_done, instr_cnt} !==
             {e.e_step, e.e_run, e.e_halt, e.e_done, e.e_cnt}) begin
            errors++;
            $display("FAIL %s: got step=%0d run=%b halt=%b done=%b cnt=%0d, want step=%0d run=%b halt=%b done=%b cnt=%0d",
                     e.name, step, running, halted, instr_done, instr_cnt,
                     e.e_step, e.e_run, e.e_halt, e.e_done, e.e_cnt);
         end
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, check after the edge
   task automatic run_vec(input vec_t t);
      @(negedge clk);
      rst = t.rst; start = t.start; stall = t.stall; step_clr = t.clr; halt_req = t.hreq;
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      int cnt_m;
      int step_m;
      //            name          rst st  stl clr hrq  step run hlt dn cnt
      vecs.push_back(mk("reset",      1, 0, 0, 0, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("idle_hold",  0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("start_t0",   0, 1, 0, 0, 0,   0, 1, 0, 0, 0));
      vecs.push_back(mk("seq1",       0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
      vecs.push_back(mk("seq2",       0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
      vecs.push_back(mk("seq3",       0, 0, 0, 0, 0,   3, 1, 0, 0, 0));
      vecs.push_back(mk("seq4",       0, 0, 0, 0, 0,   4, 1, 0, 0, 0));
      vecs.push_back(mk("seq5",       0, 0, 0, 0, 0,   5, 1, 0, 0, 0));
      vecs.push_back(mk("wrap",       0, 0, 0, 0, 0,   0, 1, 0, 1, 1));
      vecs.push_back(mk("after_wrap", 0, 0, 0, 0, 0,   1, 1, 0, 0, 1));
      vecs.push_back(mk("to2",        0, 0, 0, 0, 0,   2, 1, 0, 0, 1));
      vecs.push_back(mk("clr_at2",    0, 0, 0, 1, 0,   0, 1, 0, 1, 2));
      vecs.push_back(mk("r1",         0, 0, 0, 0, 0,   1, 1, 0, 0, 2));
      vecs.push_back(mk("r2",         0, 0, 0, 0, 0,   2, 1, 0, 0, 2));
      vecs.push_back(mk("r3",         0, 0, 0, 0, 0,   3, 1, 0, 0, 2));
      vecs.push_back(mk("stall_a",    0, 0, 1, 1, 0,   3, 1, 0, 0, 2));
      vecs.push_back(mk("stall_b",    0, 0, 1, 1, 0,   3, 1, 0, 0, 2));
      vecs.push_back(mk("stall_c",    0, 0, 1, 1, 0,   3, 1, 0, 0, 2));
      vecs.push_back(mk("clr_post",   0, 0, 0, 1, 0,   0, 1, 0, 1, 3));
      vecs.push_back(mk("hreq1",      0, 0, 0, 0, 1,   1, 1, 0, 0, 3));
      vecs.push_back(mk("hreq2",      0, 0, 0, 0, 1,   2, 1, 0, 0, 3));
      vecs.push_back(mk("hreq3",      0, 0, 0, 0, 1,   3, 1, 0, 0, 3));
      vecs.push_back(mk("hreq4",      0, 0, 0, 0, 1,   4, 1, 0, 0, 3));
      vecs.push_back(mk("hreq5",      0, 0, 0, 0, 1,   5, 1, 0, 0, 3));
      vecs.push_back(mk("halt",       0, 0, 0, 0, 1,   0, 0, 1, 1, 4));
      vecs.push_back(mk("halt_hold",  0, 0, 0, 0, 0,   0, 0, 1, 0, 4));
      vecs.push_back(mk("resume",     0, 1, 0, 0, 1,   0, 1, 0, 0, 4));
      vecs.push_back(mk("res_hreq",   0, 0, 0, 0, 1,   1, 1, 0, 0, 4));
      vecs.push_back(mk("clr_at1",    0, 0, 0, 1, 0,   0, 1, 0, 1, 5));
      vecs.push_back(mk("clr_at0a",   0, 0, 0, 1, 0,   0, 1, 0, 1, 6));
      vecs.push_back(mk("clr_at0b",   0, 0, 0, 1, 0,   0, 1, 0, 1, 7));
      vecs.push_back(mk("c1",         0, 0, 0, 0, 0,   1, 1, 0, 0, 7));
      vecs.push_back(mk("c2",         0, 0, 0, 0, 0,   2, 1, 0, 0, 7));
      vecs.push_back(mk("c3",         0, 0, 0, 0, 0,   3, 1, 0, 0, 7));
      vecs.push_back(mk("c4",         0, 0, 0, 0, 0,   4, 1, 0, 0, 7));
      vecs.push_back(mk("rst_mid",    1, 1, 0, 0, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("idle_again", 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
      vecs.push_back(mk("start_stl",  0, 1, 1, 0, 0,   0, 1, 0, 0, 0));
      vecs.push_back(mk("stall_t0",   0, 0, 1, 0, 0,   0, 1, 0, 0, 0));
      vecs.push_back(mk("stall_hreq", 0, 0, 1, 1, 1,   0, 1, 0, 0, 0));
      vecs.push_back(mk("unstall",    0, 0, 0, 0, 0,   1, 1, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i]);
      end

      // Counter wrap: a run of one-step instructions through 2^CNT_W
      cnt_m = 0;
      for (int i = 0; i < 256; i++) begin
         cnt_m = (cnt_m + 1) % 256;
         run_vec(mk("cnt_wrap", 0, 0, 0, 1, 0, 0, 1, 0, 1, cnt_m));
      end

`ifdef CTRL_SINGLE_STEP_EN
      // Single-step: only a 0->1 button edge advances the step
      step_m = 0;
      @(negedge clk);
      single_step = 1'b1;
      step_btn = 1'b0;
      run_vec(mk("ss_nobtn", 0, 0, 0, 0, 0, 0, 1, 0, 0, cnt_m));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         step_btn = 1'b1;
         if (i == 0) step_m = step_m + 1;
         run_vec(mk("ss_held", 0, 0, 0, 0, 0, step_m, 1, 0, 0, cnt_m));
      end
      @(negedge clk);
      step_btn = 1'b0;
      run_vec(mk("ss_release", 0, 0, 0, 0, 0, step_m, 1, 0, 0, cnt_m));
      @(negedge clk);
      step_btn = 1'b1;
      step_m = step_m + 1;
      run_vec(mk("ss_edge2", 0, 0, 0, 0, 0, step_m, 1, 0, 0, cnt_m));
      @(negedge clk);
      single_step = 1'b0;
      step_btn = 1'b0;
`else
      step_m = 1;
      run_vec(mk("post_wrap", 0, 0, 0, 0, 0, step_m, 1, 0, 0, cnt_m));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
